// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse-count link (burst transmitter and receiver).
//   state_t   : burst generator FSM state encoding
//   DEF_CNT_W : default pulse count width, common to both ends of the link
//   max2      : elaboration-time helper for sizing the phase counter
package pulse_pkg;

    localparam int DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2,
        ST_FIN  = 2'd3
    } state_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter timing one HIGH or LOW phase of a pulse.
// Ports:
//   clk        : system clock
//   rst_n      : asynchronous active-low reset (count cleared)
//   i_load     : load i_load_val (takes priority over decrement)
//   i_load_val : value to load, phase length minus one
//   i_dec      : decrement by one, saturating at zero
//   o_zero     : count is zero (last cycle of the phase)
module pulse_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_burst_gen.sv
// Pulse burst generator: emits `num` rectangular pulses of HIGH_W high and
// LOW_W low clk cycles on a start command, with busy/done status and a
// synchronous abort. Every output comes straight from a flop.
//
// Optional feature macro: PULSE_BURST_TOGGLE_OUT_EN
//   When defined, adds output `toggle`, which inverts on every pulse rise.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   start  : burst request, sampled only in IDLE
//   num    : pulse count, sampled together with start
//   abort  : synchronous abort of the current burst
//   pulse  : registered pulse output
//   busy   : high while a burst is in progress (including the FIN cycle)
//   done   : one-cycle strobe on normal completion
//   sent   : pulses fully emitted in the current or last burst
//   toggle : (macro only) inverts on each pulse rise
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start; outputs low, sent holds last count
// HIGH    | pulse high, phase timer counting HIGH_W cycles
// LOW     | pulse low, phase timer counting LOW_W cycles
// FIN     | single cycle with done=1, busy=1; returns to IDLE
module pulse_burst_gen
    import pulse_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int HIGH_W = 2,
    parameter int LOW_W  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num,
    input  logic             abort,
    output logic             pulse,
    output logic             busy,
    output logic             done,
`ifdef PULSE_BURST_TOGGLE_OUT_EN
    output logic             toggle,
`endif
    output logic [CNT_W-1:0] sent
);

    localparam int PH_W = $clog2(max2(HIGH_W, LOW_W) + 1);
    localparam logic [PH_W-1:0] HIGH_LD = PH_W'(HIGH_W - 1);
    localparam logic [PH_W-1:0] LOW_LD  = PH_W'(LOW_W - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_num;
    logic [CNT_W-1:0] r_sent;
    logic             r_pulse;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_num_nxt;
    logic [CNT_W-1:0] w_sent_nxt;
    logic             w_pulse_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_tmr_load;
    logic [PH_W-1:0]  w_tmr_ld_val;
    logic             w_tmr_dec;
    logic             w_tmr_zero;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
    logic             w_rise;
    logic             r_toggle;
`endif

    pulse_phase_timer #(
        .W (PH_W)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_ld_val),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_num   <= '0;
            r_sent  <= '0;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_num   <= w_num_nxt;
            r_sent  <= w_sent_nxt;
            r_pulse <= w_pulse_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_num_nxt    = r_num;
        w_sent_nxt   = r_sent;
        w_pulse_nxt  = 1'b0;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;
        w_tmr_load   = 1'b0;
        w_tmr_ld_val = HIGH_LD;
        w_tmr_dec    = 1'b0;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        w_rise       = 1'b0;
`endif

        unique case (r_state)
            ST_IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    w_sent_nxt = '0;
                    w_busy_nxt = 1'b1;
                    if (num != '0) begin
                        w_num_nxt    = num;
                        w_tmr_load   = 1'b1;
                        w_tmr_ld_val = HIGH_LD;
                        w_pulse_nxt  = 1'b1;
                        w_state_nxt  = ST_HIGH;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
                        w_rise       = 1'b1;
`endif
                    end else begin
                        w_num_nxt   = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_FIN;
                    end
                end
            end

            ST_HIGH: begin
                if (abort) begin
                    // truncated high phase is not counted in sent
                    w_state_nxt = ST_IDLE;
                end else if (w_tmr_zero) begin
                    w_sent_nxt   = r_sent + 1'b1;
                    w_tmr_load   = 1'b1;
                    w_tmr_ld_val = LOW_LD;
                    w_busy_nxt   = 1'b1;
                    w_state_nxt  = ST_LOW;
                end else begin
                    w_tmr_dec   = 1'b1;
                    w_pulse_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end
            end

            ST_LOW: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tmr_zero) begin
                    w_busy_nxt = 1'b1;
                    if (r_sent == r_num) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_FIN;
                    end else begin
                        w_tmr_load   = 1'b1;
                        w_tmr_ld_val = HIGH_LD;
                        w_pulse_nxt  = 1'b1;
                        w_state_nxt  = ST_HIGH;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
                        w_rise       = 1'b1;
`endif
                    end
                end else begin
                    w_tmr_dec  = 1'b1;
                    w_busy_nxt = 1'b1;
                end
            end

            ST_FIN: begin
                // busy and done drop together on the way back to IDLE
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef PULSE_BURST_TOGGLE_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_toggle <= 1'b0;
        end else if (w_rise) begin
            r_toggle <= ~r_toggle;
        end
    end

    assign toggle = r_toggle;
`endif

    assign pulse = r_pulse;
    assign busy  = r_busy;
    assign done  = r_done;
    assign sent  = r_sent;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed self-checking bench for pulse_burst_gen.
// Instance a: HIGH_W=2, LOW_W=2.  Instance b: HIGH_W=1, LOW_W=1.
module tb_pulse_burst_gen;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_b, abort_a, abort_b;
    logic [3:0] num_a, num_b;
    logic       pulse_a, busy_a, done_a;
    logic       pulse_b, busy_b, done_b;
    logic [3:0] sent_a, sent_b;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
    logic       toggle_a, toggle_b;
    logic       tog_prev_a;
    int         tog_cnt_a;
`endif

    int checks;
    int errors;
    int done_tot_a;

    pulse_burst_gen #(.CNT_W(4), .HIGH_W(2), .LOW_W(2)) dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_a),
        .num    (num_a),
        .abort  (abort_a),
        .pulse  (pulse_a),
        .busy   (busy_a),
        .done   (done_a),
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        .toggle (toggle_a),
`endif
        .sent   (sent_a)
    );

    pulse_burst_gen #(.CNT_W(4), .HIGH_W(1), .LOW_W(1)) dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_b),
        .num    (num_b),
        .abort  (abort_b),
        .pulse  (pulse_b),
        .busy   (busy_b),
        .done   (done_b),
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        .toggle (toggle_b),
`endif
        .sent   (sent_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done_a === 1'b1) done_tot_a = done_tot_a + 1;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        if (toggle_a !== tog_prev_a) tog_cnt_a = tog_cnt_a + 1;
        tog_prev_a = toggle_a;
`endif
    end

    // Called at a negedge; start is seen by the next posedge. Returns at the
    // following negedge with start released (cycle 1 of the burst).
    task automatic do_start(input bit sel, input logic [3:0] n);
        if (sel) begin start_b = 1'b1; num_b = n; end
        else     begin start_a = 1'b1; num_a = n; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Samples one instance every negedge until busy is low. Optionally
    // re-asserts start (num=9) on cycle restart_at to probe the ignore path.
    task automatic collect(input bit sel, input int restart_at,
                           output int rises, output int busy_cyc, output int done_cyc,
                           output int hmin, output int hmax, output bit tout);
        logic p, b, d, prev;
        int   cyc, run;
        prev = 1'b0; cyc = 0; run = 0;
        rises = 0; busy_cyc = 0; done_cyc = 0; hmin = 1000; hmax = 0; tout = 1'b0;
        forever begin
            p = sel ? pulse_b : pulse_a;
            b = sel ? busy_b  : busy_a;
            d = sel ? done_b  : done_a;
            if (p && !prev) rises++;
            if (p) run++;
            else if (prev) begin
                if (run < hmin) hmin = run;
                if (run > hmax) hmax = run;
                run = 0;
            end
            if (b) busy_cyc++;
            if (d) done_cyc++;
            prev = p;
            start_a = 1'b0;
            if (!b) break;
            if (cyc >= 1000) begin tout = 1'b1; break; end
            if (!sel && cyc == restart_at) begin start_a = 1'b1; num_a = 4'd9; end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({pulse_a, busy_a, done_a, sent_a} !== 7'd0) begin
            errors++; $display("FAIL reset_a: got p%b b%b d%b s%0d, expected all 0", pulse_a, busy_a, done_a, sent_a);
        end
        checks++;
        if ({pulse_b, busy_b, done_b, sent_b} !== 7'd0) begin
            errors++; $display("FAIL reset_b: got p%b b%b d%b s%0d, expected all 0", pulse_b, busy_b, done_b, sent_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int r, bc, dc, hn, hx, tg0; bit to;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        tg0 = tog_cnt_a;
`else
        tg0 = 0;
`endif
        do_start(1'b0, 4'd3);
        checks++;
        if (pulse_a !== 1'b1) begin errors++; $display("FAIL basic_first_pulse: got %b expected 1", pulse_a); end
        collect(1'b0, -1, r, bc, dc, hn, hx, to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: burst did not finish"); end
        checks++; if (r != 3) begin errors++; $display("FAIL basic_pulses: got %0d expected 3", r); end
        checks++; if (bc != 13) begin errors++; $display("FAIL basic_busy: got %0d expected 13", bc); end
        checks++; if (dc != 1) begin errors++; $display("FAIL basic_done: got %0d expected 1", dc); end
        checks++;
        if (hn != 2 || hx != 2) begin errors++; $display("FAIL basic_high_width: got min %0d max %0d expected 2", hn, hx); end
        checks++; if (sent_a !== 4'd3) begin errors++; $display("FAIL basic_sent: got %0d expected 3", sent_a); end
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        checks++;
        if (tog_cnt_a - tg0 != 3) begin errors++; $display("FAIL basic_toggle: got %0d expected 3", tog_cnt_a - tg0); end
`endif
        if (tg0 < 0) $display("unexpected toggle count");
    endtask

    task automatic test_zero();
        int r, bc, dc, hn, hx; bit to;
        do_start(1'b0, 4'd0);
        collect(1'b0, -1, r, bc, dc, hn, hx, to);
        checks++; if (to) begin errors++; $display("FAIL zero_timeout: burst did not finish"); end
        checks++; if (r != 0) begin errors++; $display("FAIL zero_pulses: got %0d expected 0", r); end
        checks++; if (bc != 1) begin errors++; $display("FAIL zero_busy: got %0d expected 1", bc); end
        checks++; if (dc != 1) begin errors++; $display("FAIL zero_done: got %0d expected 1", dc); end
        checks++; if (sent_a !== 4'd0) begin errors++; $display("FAIL zero_sent: got %0d expected 0", sent_a); end
    endtask

    task automatic test_max();
        int r, bc, dc, hn, hx; bit to;
        do_start(1'b1, 4'd15);
        collect(1'b1, -1, r, bc, dc, hn, hx, to);
        checks++; if (to) begin errors++; $display("FAIL max_timeout: burst did not finish"); end
        checks++; if (r != 15) begin errors++; $display("FAIL max_pulses: got %0d expected 15", r); end
        checks++; if (bc != 31) begin errors++; $display("FAIL max_busy: got %0d expected 31", bc); end
        checks++; if (dc != 1) begin errors++; $display("FAIL max_done: got %0d expected 1", dc); end
        checks++;
        if (hn != 1 || hx != 1) begin errors++; $display("FAIL max_high_width: got min %0d max %0d expected 1", hn, hx); end
        checks++; if (sent_b !== 4'd15) begin errors++; $display("FAIL max_sent: got %0d expected 15", sent_b); end
    endtask

    task automatic test_abort();
        int r, bc, dc, hn, hx, d0, tg0; bit to;
        d0 = done_tot_a;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        tg0 = tog_cnt_a;
`else
        tg0 = 0;
`endif
        do_start(1'b0, 4'd5);
        repeat (8) @(negedge clk);
        checks++;
        if (pulse_a !== 1'b1 || sent_a !== 4'd2) begin
            errors++; $display("FAIL abort_pre: got p%b s%0d expected p1 s2", pulse_a, sent_a);
        end
        abort_a = 1'b1;
        @(negedge clk);
        abort_a = 1'b0;
        checks++;
        if ({pulse_a, busy_a, done_a} !== 3'b000) begin
            errors++; $display("FAIL abort_outputs: got p%b b%b d%b expected 000", pulse_a, busy_a, done_a);
        end
        checks++; if (sent_a !== 4'd2) begin errors++; $display("FAIL abort_sent: got %0d expected 2", sent_a); end
        checks++; if (done_tot_a != d0) begin errors++; $display("FAIL abort_no_done: got %0d strobes expected 0", done_tot_a - d0); end
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        checks++;
        if (tog_cnt_a - tg0 != 3) begin errors++; $display("FAIL abort_toggle: got %0d expected 3", tog_cnt_a - tg0); end
`endif
        if (tg0 < 0) $display("unexpected toggle count");
        do_start(1'b0, 4'd1);
        checks++;
        if (busy_a !== 1'b1 || pulse_a !== 1'b1) begin
            errors++; $display("FAIL abort_restart: got b%b p%b expected b1 p1", busy_a, pulse_a);
        end
        collect(1'b0, -1, r, bc, dc, hn, hx, to);
        checks++;
        if (to || r != 1 || dc != 1) begin errors++; $display("FAIL abort_restart_burst: got pulses %0d done %0d expected 1 1", r, dc); end
    endtask

    task automatic test_abort_idle();
        start_a = 1'b1; abort_a = 1'b1; num_a = 4'd3;
        @(negedge clk);
        start_a = 1'b0; abort_a = 1'b0;
        checks++;
        if (busy_a !== 1'b0 || pulse_a !== 1'b0) begin
            errors++; $display("FAIL abort_idle: got b%b p%b expected b0 p0", busy_a, pulse_a);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int r, bc, dc, hn, hx; bit to;
        do_start(1'b0, 4'd4);
        collect(1'b0, 3, r, bc, dc, hn, hx, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: burst did not finish"); end
        checks++; if (r != 4) begin errors++; $display("FAIL b2b_pulses: got %0d expected 4", r); end
        checks++; if (bc != 17) begin errors++; $display("FAIL b2b_busy: got %0d expected 17", bc); end
        checks++; if (sent_a !== 4'd4) begin errors++; $display("FAIL b2b_sent: got %0d expected 4", sent_a); end
        do_start(1'b0, 4'd2);
        checks++;
        if (busy_a !== 1'b1) begin errors++; $display("FAIL b2b_after_fin: got busy %b expected 1", busy_a); end
        collect(1'b0, -1, r, bc, dc, hn, hx, to);
        checks++;
        if (to || r != 2 || bc != 9) begin errors++; $display("FAIL b2b_second: got pulses %0d busy %0d expected 2 9", r, bc); end
    endtask

    task automatic test_async_reset();
        do_start(1'b0, 4'd3);
        repeat (4) @(negedge clk);
        checks++;
        if (pulse_a !== 1'b1 || sent_a !== 4'd1) begin
            errors++; $display("FAIL areset_pre: got p%b s%0d expected p1 s1", pulse_a, sent_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({pulse_a, busy_a, done_a, sent_a} !== 7'd0) begin
            errors++; $display("FAIL areset: got p%b b%b d%b s%0d expected all 0", pulse_a, busy_a, done_a, sent_a);
        end
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        checks++;
        if (toggle_a !== 1'b0) begin errors++; $display("FAIL areset_toggle: got %b expected 0", toggle_a); end
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_a !== 1'b0 || pulse_a !== 1'b0) begin
            errors++; $display("FAIL areset_idle: got b%b p%b expected b0 p0", busy_a, pulse_a);
        end
    endtask

    initial begin
        checks = 0; errors = 0; done_tot_a = 0;
`ifdef PULSE_BURST_TOGGLE_OUT_EN
        tog_cnt_a = 0; tog_prev_a = 1'b0;
`endif
        start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
        num_a = 4'd0; num_b = 4'd0;
        test_reset();
        test_basic();
        test_zero();
        test_max();
        test_abort();
        test_abort_idle();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
